miriscv_lsu_bus: RTL and testbench

Parametrised load/store unit that replaces the single-cycle combinational LSU with a registered, handshaked memory interface (req/gnt/rvalid/err).
- Supports XLEN 32 or 64.
- Detects misaligned accesses and illegal sizes.
- Stalls the core until the bus transaction completes.
- Sits between the core execute stage and the data memory or bus interconnect.

---
 rtl/miriscv_lsu_pkg.sv | 47 ++++
 rtl/miriscv_lsu_load_ext.sv | 32 +++
 rtl/miriscv_lsu_bus.sv | 165 ++++++++++++++++
 tb/tb_miriscv_lsu_bus.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/miriscv_lsu_pkg.sv
// Shared types and helpers for the handshaked load/store unit.
package miriscv_lsu_pkg;

    // Access size encoding on lsu_size_i
    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_D  = 3'd3;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;
    localparam logic [2:0] SZ_WU = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_DONE
    } lsu_state_e;

    // Byte enables for an 8-lane bus; narrower buses keep the low lanes
    function automatic logic [7:0] lsu_byte_en(input logic [2:0] size, input logic [2:0] off);
        logic [7:0] be;
        case (size)
            SZ_B, SZ_BU: be = 8'h01 << off;
            SZ_H, SZ_HU: be = 8'h03 << off;
            SZ_W, SZ_WU: be = 8'h0F << off;
            default:     be = 8'hFF;
        endcase
        return be;
    endfunction

    // 1 when the size exists for this XLEN and the offset is naturally aligned
    function automatic logic lsu_access_ok(input logic [2:0] size, input logic [2:0] off,
                                           input logic is64);
        logic ok;
        case (size)
            SZ_B, SZ_BU: ok = 1'b1;
            SZ_H, SZ_HU: ok = ~off[0];
            SZ_W:        ok = (off[1:0] == 2'b00);
            SZ_WU:       ok = is64 && (off[1:0] == 2'b00);
            SZ_D:        ok = is64 && (off == 3'b000);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/miriscv_lsu_load_ext.sv
// Load lane select plus sign/zero extension of the bus read data.
module miriscv_lsu_load_ext
    import miriscv_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]           rdata,
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic [2:0]                size,
    output logic [XLEN-1:0]           data
);

    logic [XLEN-1:0] lane;

    // Move the addressed byte lane down to bit 0
    assign lane = rdata >> {off, 3'b000};

    // Extend the selected field to full width
    always_comb begin
        data = lane;
        case (size)
            SZ_B:    data = XLEN'($signed(lane[7:0]));
            SZ_BU:   data = XLEN'(lane[7:0]);
            SZ_H:    data = XLEN'($signed(lane[15:0]));
            SZ_HU:   data = XLEN'(lane[15:0]);
            SZ_W:    data = XLEN'($signed(lane[31:0]));
            SZ_WU:   data = XLEN'(lane[31:0]);
            default: data = lane;
        endcase
    end

endmodule

// File: rtl/miriscv_lsu_bus.sv
// Registered req/gnt/rvalid load/store unit; stalls the core until the bus
// transaction finishes. Optional bus timeout: MIRISCV_LSU_TIMEOUT_EN.
module miriscv_lsu_bus
    import miriscv_lsu_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [2:0]        lsu_size_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [XLEN-1:0]   lsu_data_i,
    output logic              lsu_stall_req_o,
    output logic [XLEN-1:0]   lsu_data_o,
    output logic              lsu_misalign_o,
    output logic              lsu_err_o,
    output logic              data_req_o,
    input  logic              data_gnt_i,
    output logic              data_we_o,
    output logic [XLEN/8-1:0] data_be_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [XLEN-1:0]   data_wdata_o,
    input  logic              data_rvalid_i,
    input  logic [XLEN-1:0]   data_rdata_i,
    input  logic              data_err_i
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    lsu_state_e       state_q;
    logic             we_q;
    logic [2:0]       size_q;
    logic [OFF_W-1:0] off_q;
    logic [OFF_W-1:0] off_in;
    logic             access_ok_c;
    logic [NB-1:0]    be_c;
    logic [XLEN-1:0]  wdata_c;
    logic [XLEN-1:0]  load_data_c;

`ifdef MIRISCV_LSU_TIMEOUT_EN
    logic [15:0] to_cnt_q;
    logic        to_hit_c;

    // Timeout fires after TIMEOUT_CYC cycles spent in REQ/RESP
    assign to_hit_c = (to_cnt_q == 16'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;

    assign unused_timeout = ^32'(TIMEOUT_CYC);
`endif

    // Request decode from the live core inputs (only consumed in IDLE)
    assign off_in      = lsu_addr_i[OFF_W-1:0];
    assign access_ok_c = lsu_access_ok(lsu_size_i, 3'(off_in), XLEN == 64);
    assign be_c        = NB'(lsu_byte_en(lsu_size_i, 3'(off_in)));

    // Core is held until the one-cycle DONE state
    assign lsu_stall_req_o = lsu_req_i && (state_q != ST_DONE);

    // Replicate store data so every enabled lane carries it
    always_comb begin
        wdata_c = lsu_data_i;
        case (lsu_size_i)
            SZ_B, SZ_BU: wdata_c = {NB{lsu_data_i[7:0]}};
            SZ_H, SZ_HU: wdata_c = {(XLEN/16){lsu_data_i[15:0]}};
            SZ_W, SZ_WU: wdata_c = {(XLEN/32){lsu_data_i[31:0]}};
            default:     wdata_c = lsu_data_i;
        endcase
    end

    miriscv_lsu_load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .rdata (data_rdata_i),
        .off   (off_q),
        .size  (size_q),
        .data  (load_data_c)
    );

    // Transaction FSM with all core- and bus-facing outputs registered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            we_q           <= 1'b0;
            size_q         <= 3'd0;
            off_q          <= '0;
            lsu_data_o     <= '0;
            lsu_misalign_o <= 1'b0;
            lsu_err_o      <= 1'b0;
            data_req_o     <= 1'b0;
            data_we_o      <= 1'b0;
            data_be_o      <= '0;
            data_addr_o    <= '0;
            data_wdata_o   <= '0;
`ifdef MIRISCV_LSU_TIMEOUT_EN
            to_cnt_q       <= 16'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (lsu_req_i) begin
                        we_q   <= lsu_we_i;
                        size_q <= lsu_size_i;
                        off_q  <= off_in;
                        if (!access_ok_c) begin
                            lsu_misalign_o <= 1'b1;
                            state_q        <= ST_DONE;
                        end else begin
                            data_req_o   <= 1'b1;
                            data_we_o    <= lsu_we_i;
                            data_be_o    <= be_c;
                            data_addr_o  <= {lsu_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
                            data_wdata_o <= wdata_c;
`ifdef MIRISCV_LSU_TIMEOUT_EN
                            to_cnt_q     <= 16'd0;
`endif
                            state_q      <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
`ifdef MIRISCV_LSU_TIMEOUT_EN
                    to_cnt_q <= to_cnt_q + 16'd1;
                    if (to_hit_c) begin
                        data_req_o <= 1'b0;
                        lsu_err_o  <= 1'b1;
                        state_q    <= ST_DONE;
                    end else
`endif
                    if (data_gnt_i) begin
                        data_req_o <= 1'b0;
                        state_q    <= ST_RESP;
                    end
                end
                ST_RESP: begin
`ifdef MIRISCV_LSU_TIMEOUT_EN
                    to_cnt_q <= to_cnt_q + 16'd1;
                    if (to_hit_c) begin
                        lsu_err_o <= 1'b1;
                        state_q   <= ST_DONE;
                    end else
`endif
                    if (data_rvalid_i) begin
                        lsu_err_o <= data_err_i;
                        if (!we_q && !data_err_i) begin
                            lsu_data_o <= load_data_c;
                        end
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    lsu_misalign_o <= 1'b0;
                    lsu_err_o      <= 1'b0;
                    state_q        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_miriscv_lsu_bus.sv
// Scoreboard bench for miriscv_lsu_bus: a 32-bit and a 64-bit instance share
// one stimulus driver; sel64 routes requests and selects which outputs are viewed.
module tb_miriscv_lsu_bus;

    typedef struct {
        logic        mis;
        logic        err;
        logic [63:0] data;
        int          stall;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel64 = 1'b0;
    logic        lsu_req = 1'b0;
    logic        lsu_we = 1'b0;
    logic [2:0]  lsu_size = 3'd0;
    logic [31:0] lsu_addr = 32'd0;
    logic [63:0] lsu_data = 64'd0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [63:0] rdata = 64'd0;
    logic        rerr = 1'b0;

    int   n_checks = 0;
    int   n_errors = 0;
    int   mon_stall = 0;
    exp_t sb_q[$];

    wire req32 = lsu_req & ~sel64;
    wire req64 = lsu_req & sel64;
    wire gnt32 = gnt & ~sel64;
    wire gnt64 = gnt & sel64;
    wire rv32  = rvalid & ~sel64;
    wire rv64  = rvalid & sel64;

    logic        stall32, mis32, err32, breq32, we32;
    logic [31:0] data32, addr32, wdata32;
    logic [3:0]  be32;
    logic        stall64, mis64, err64, breq64, we64;
    logic [63:0] data64, wdata64;
    logic [31:0] addr64;
    logic [7:0]  be64;

    logic        v_stall, v_mis, v_err, v_req, v_we;
    logic [63:0] v_data, v_wdata;
    logic [31:0] v_addr;
    logic [7:0]  v_be;

    always #5 clk = ~clk;

    miriscv_lsu_bus #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(8)) u_dut32 (
        .clk_i(clk), .rst_i(rst),
        .lsu_req_i(req32), .lsu_we_i(lsu_we), .lsu_size_i(lsu_size),
        .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data[31:0]),
        .lsu_stall_req_o(stall32), .lsu_data_o(data32),
        .lsu_misalign_o(mis32), .lsu_err_o(err32),
        .data_req_o(breq32), .data_gnt_i(gnt32), .data_we_o(we32),
        .data_be_o(be32), .data_addr_o(addr32), .data_wdata_o(wdata32),
        .data_rvalid_i(rv32), .data_rdata_i(rdata[31:0]), .data_err_i(rerr)
    );

    miriscv_lsu_bus #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYC(8)) u_dut64 (
        .clk_i(clk), .rst_i(rst),
        .lsu_req_i(req64), .lsu_we_i(lsu_we), .lsu_size_i(lsu_size),
        .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data),
        .lsu_stall_req_o(stall64), .lsu_data_o(data64),
        .lsu_misalign_o(mis64), .lsu_err_o(err64),
        .data_req_o(breq64), .data_gnt_i(gnt64), .data_we_o(we64),
        .data_be_o(be64), .data_addr_o(addr64), .data_wdata_o(wdata64),
        .data_rvalid_i(rv64), .data_rdata_i(rdata), .data_err_i(rerr)
    );

    // View of whichever instance is selected
    always_comb begin
        v_stall = sel64 ? stall64 : stall32;
        v_mis   = sel64 ? mis64   : mis32;
        v_err   = sel64 ? err64   : err32;
        v_req   = sel64 ? breq64  : breq32;
        v_we    = sel64 ? we64    : we32;
        v_data  = sel64 ? data64  : {32'd0, data32};
        v_wdata = sel64 ? wdata64 : {32'd0, wdata32};
        v_addr  = sel64 ? addr64  : addr32;
        v_be    = sel64 ? be64    : {4'd0, be32};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: counts stalled cycles and checks the result when DONE is presented
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_stall = 0;
            end else if (lsu_req) begin
                if (v_stall) begin
                    mon_stall++;
                end else begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL sb_unexpected_done: got done, expected no transaction");
                    end else begin
                        e = sb_q.pop_front();
                        chk("done_misalign", 64'(v_mis), 64'(e.mis));
                        chk("done_err", 64'(v_err), 64'(e.err));
                        chk("done_data", v_data, e.data);
                        chk("stall_cycles", 64'(mon_stall), 64'(e.stall));
                    end
                    mon_stall = 0;
                end
            end
        end
    end

    // Issue one access on the selected instance; entered and left at posedge+1 in IDLE
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [63:0] wd, input int gnt_dly, input logic [63:0] rd,
                          input logic err_in, input logic bad, input logic [7:0] exp_be,
                          input logic [63:0] exp_wd, input logic e_mis, input logic e_err,
                          input logic [63:0] e_data, input int e_stall);
        exp_t e;
        logic [31:0] exp_addr;
        int n;
        e.mis = e_mis; e.err = e_err; e.data = e_data; e.stall = e_stall;
        sb_q.push_back(e);
        exp_addr = sel64 ? {addr[31:3], 3'b000} : {addr[31:2], 2'b00};
        lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_addr = addr; lsu_data = wd;
        @(posedge clk); #1;
        if (bad) begin
            chk("no_bus_req", 64'(v_req), 64'd0);
        end else begin
            chk("bus_req", 64'(v_req), 64'd1);
            chk("bus_we", 64'(v_we), 64'(we));
            chk("bus_be", 64'(v_be), 64'(exp_be));
            chk("bus_addr", 64'(v_addr), 64'(exp_addr));
            chk("bus_wdata", v_wdata, exp_wd);
            if (gnt_dly < 0) begin
                n = 1;
                while (v_req && n < 40) begin
                    @(posedge clk); #1;
                    if (v_req) n++;
                end
                chk("timeout_req_cycles", 64'(n), 64'd8);
            end else begin
                for (int i = 0; i < gnt_dly; i++) begin
                    @(posedge clk); #1;
                    chk("hold_req", 64'(v_req), 64'd1);
                    chk("hold_be", 64'(v_be), 64'(exp_be));
                    chk("hold_addr", 64'(v_addr), 64'(exp_addr));
                end
                gnt = 1'b1;
                @(posedge clk); #1;
                gnt = 1'b0;
                chk("req_drop", 64'(v_req), 64'd0);
                rvalid = 1'b1; rdata = rd; rerr = err_in;
                @(posedge clk); #1;
                rvalid = 1'b0; rerr = 1'b0;
            end
        end
        @(negedge clk); #1;
        lsu_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 64'(v_stall), 64'd0);
        chk({tag, "_req"}, 64'(v_req), 64'd0);
        chk({tag, "_we"}, 64'(v_we), 64'd0);
        chk({tag, "_be"}, 64'(v_be), 64'd0);
        chk({tag, "_addr"}, 64'(v_addr), 64'd0);
        chk({tag, "_wdata"}, v_wdata, 64'd0);
        chk({tag, "_data"}, v_data, 64'd0);
        chk({tag, "_mis"}, 64'(v_mis), 64'd0);
        chk({tag, "_err"}, 64'(v_err), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        sel64 = 1'b0; #1 chk_all_zero("rst32");
        sel64 = 1'b1; #1 chk_all_zero("rst64");
        sel64 = 1'b0;
        @(posedge clk); #1;

        // 32-bit:    we    size  addr          wdata        gnt rdata          err bad be        wdata_exp     mis err data            stall
        access(1'b0, 3'd2, 32'h100, 64'h0,        0, 64'hDEADBEEF, 0, 0, 8'h0F, 64'h0,        0, 0, 64'hDEADBEEF, 3);
        access(1'b0, 3'd0, 32'h203, 64'h0,        0, 64'h80FF0000, 0, 0, 8'h08, 64'h0,        0, 0, 64'hFFFFFF80, 3);
        access(1'b0, 3'd4, 32'h203, 64'h0,        0, 64'h80FF0000, 0, 0, 8'h08, 64'h0,        0, 0, 64'h00000080, 3);
        access(1'b1, 3'd1, 32'h302, 64'h1234,     0, 64'hFFFFFFFF, 0, 0, 8'h0C, 64'h12341234, 0, 0, 64'h00000080, 3);
        access(1'b1, 3'd0, 32'h001, 64'hA5,       0, 64'h0,        0, 0, 8'h02, 64'hA5A5A5A5, 0, 0, 64'h00000080, 3);
        access(1'b0, 3'd5, 32'h102, 64'h0,        0, 64'hBEEF1234, 0, 0, 8'h0C, 64'h0,        0, 0, 64'h0000BEEF, 3);
        access(1'b0, 3'd1, 32'h102, 64'h0,        0, 64'hBEEF1234, 0, 0, 8'h0C, 64'h0,        0, 0, 64'hFFFFBEEF, 3);
        access(1'b0, 3'd2, 32'h101, 64'h0,        0, 64'h0,        0, 1, 8'h00, 64'h0,        1, 0, 64'hFFFFBEEF, 1);
        access(1'b0, 3'd3, 32'h100, 64'h0,        0, 64'h0,        0, 1, 8'h00, 64'h0,        1, 0, 64'hFFFFBEEF, 1);
        access(1'b0, 3'd6, 32'h100, 64'h0,        0, 64'h0,        0, 1, 8'h00, 64'h0,        1, 0, 64'hFFFFBEEF, 1);
        access(1'b0, 3'd7, 32'h100, 64'h0,        0, 64'h0,        0, 1, 8'h00, 64'h0,        1, 0, 64'hFFFFBEEF, 1);
        access(1'b0, 3'd1, 32'h102, 64'h0,        4, 64'h5555AAAA, 1, 0, 8'h0C, 64'h0,        0, 1, 64'hFFFFBEEF, 7);

        // Reset pulsed while waiting for the response
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'd2; lsu_addr = 32'h100;
        @(posedge clk); #1;
        gnt = 1'b1;
        @(posedge clk); #1;
        gnt = 1'b0; rst = 1'b1; lsu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_all_zero("rst_resp");
        rvalid = 1'b1; rdata = 64'h12345678;
        @(posedge clk); #1;
        rvalid = 1'b0;
        chk("late_rvalid_data", v_data, 64'd0);
        chk("late_rvalid_req", 64'(v_req), 64'd0);
        chk("late_rvalid_err", 64'(v_err), 64'd0);
        access(1'b0, 3'd2, 32'h100, 64'h0,        0, 64'h0BADF00D, 0, 0, 8'h0F, 64'h0,        0, 0, 64'h0BADF00D, 3);

        // 64-bit instance
        sel64 = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 3'd3, 32'h008, 64'h0, 0, 64'h0123456789ABCDEF, 0, 0, 8'hFF, 64'h0, 0, 0, 64'h0123456789ABCDEF, 3);
        access(1'b0, 3'd2, 32'h00C, 64'h0, 0, 64'h8000000000000000, 0, 0, 8'hF0, 64'h0, 0, 0, 64'hFFFFFFFF80000000, 3);
        access(1'b0, 3'd6, 32'h00C, 64'h0, 0, 64'h8000000000000000, 0, 0, 8'hF0, 64'h0, 0, 0, 64'h0000000080000000, 3);
        access(1'b1, 3'd2, 32'h004, 64'hCAFEF00D, 0, 64'h0, 0, 0, 8'hF0, 64'hCAFEF00DCAFEF00D, 0, 0, 64'h0000000080000000, 3);
        access(1'b0, 3'd3, 32'h004, 64'h0, 0, 64'h0, 0, 1, 8'h00, 64'h0, 1, 0, 64'h0000000080000000, 1);

`ifdef MIRISCV_LSU_TIMEOUT_EN
        // Grant never arrives: the 8-cycle timeout ends the transaction
        sel64 = 1'b0;
        @(posedge clk); #1;
        access(1'b0, 3'd2, 32'h200, 64'h0, -1, 64'h0, 0, 0, 8'h0F, 64'h0, 0, 1, 64'h0BADF00D, 9);
`endif

        repeat (3) @(posedge clk);
        #1 chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global bound so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
